barrier_arrival_tracker: RTL and testbench
==========================================

# barrier_arrival_tracker

Per-level arrival collector that sits directly upstream of the multilevel barrier. It counts thread arrivals on each barrier level and drives the barrier's per-level wait inputs. It consumes the barrier's release pulse and hands the set of parked threads back to the scheduler as a wake mask over a valid/ready handshake.

## Interface
- NUM_LEVELS, 5, number of barrier levels; equals the barrier's NUM_LEVELS
- NUM_THREADS, 16, number of hardware threads that can park
- LEVEL_W, $clog2(NUM_LEVELS), level index width
- THREAD_W, $clog2(NUM_THREADS), thread index width
- CNT_W, $clog2(NUM_THREADS+1), participant count width

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-low (0 = reset); sampled on posedge clk
- in_config_valid  in  1  arm a level
- in_config_level  in  LEVEL_W  level to arm
- in_config_count  in  CNT_W  expected arrivals for that level
- in_arrive_valid  in  1  a thread arrives at a level
- in_arrive_level  in  LEVEL_W  level arrived at
- in_arrive_thread  in  THREAD_W  arriving thread id
- out_arrive_ready  out  1  arrival accepted when valid & ready
- out_wait  out  NUM_LEVELS  to barrier in_wait; bit l high while level l is gathering
- in_release  in  1  barrier out_release; single-cycle pulse
- out_wake_valid  out  1  wake mask available
- out_wake_mask  out  NUM_THREADS  threads to resume
- in_wake_ready  in  1  scheduler accepts wake mask
- out_error  out  1  sticky protocol-error flag; cleared only by reset

## Operation
- Per-level state: IDLE (unarmed), GATHER (armed, count < expected), DONE (complete, mask held). Each level holds a CNT_W counter, a CNT_W expected value, and a NUM_THREADS thread mask.
- Global state: RUN or WAKE.
- Config, level IDLE: expected <= count; counter and mask <= 0; state -> GATHER. If the count is 0, state -> DONE.
- Config, level not IDLE: ignored; out_error <= 1.
- Config index >= NUM_LEVELS: ignored; out_error <= 1.
- out_arrive_ready = (global RUN) & !in_config_valid & reset. Config has priority over arrivals.
- Accepted arrival, level GATHER, thread not in mask: set the thread's mask bit and increment the counter. If counter+1 == expected, state -> DONE.
- Accepted arrival, level GATHER, thread already in mask: dropped; out_error <= 1.
- Accepted arrival, level IDLE or DONE, or level index >= NUM_LEVELS: dropped; out_error <= 1.
- out_wait[l] = (state[l] == GATHER), registered from state.
- in_release in RUN with at least one DONE level:
  - out_wake_mask <= OR of the masks of all DONE levels.
  - global -> WAKE.
  - GATHER levels are untouched.
- in_release in RUN with no DONE level: no effect.
- in_release in WAKE: ignored; out_error <= 1.
- WAKE: out_wake_valid = 1. The mask stays stable until in_wake_ready.
- On the wake handshake:
  - Every DONE level -> IDLE; counters and masks cleared.
  - global -> RUN.
  - out_wake_mask <= 0.
- Reset (reset == 0, any state, including mid-WAKE): every level -> IDLE, global -> RUN, counters, masks and expected values cleared.

## Timing
- Values while reset is low and on the first cycle after it: out_wait = 0, out_wake_valid = 0, out_wake_mask = 0, out_error = 0, out_arrive_ready = 0 (reset low) and 1 after.
- Config at edge N: out_wait[l] = 1 from N+1.
- Final arrival at edge N: state DONE and out_wait[l] = 0 from N+1.
- in_release at edge N: out_wake_valid = 1 from N+1. out_arrive_ready is low from N+1 until the handshake.
- Arrival and release on the same edge: the arrival is processed first. If it completes a level, that level is included in the wake mask.
- Wake handshake at edge M: out_wake_valid = 0 and out_arrive_ready = 1 from M+1. The level can be re-armed by a config at M+1.
- Config and arrival to the same level on the same edge: the arrival is not accepted (ready low).
- Counter width: CNT_W holds NUM_THREADS exactly. The counter never exceeds expected, because DONE rejects further arrivals.

## Test plan
- Single-level complete:
  - Reset, then config level 0 with count 3 -> out_wait = 00001.
  - Threads 2, 5, 7 arrive -> out_wait = 00000 one cycle after thread 7.
  - Pulse in_release -> next cycle out_wake_valid = 1, out_wake_mask = 0x00A4.
  - Raise in_wake_ready -> next cycle valid = 0 and ready = 1.
- Multi-level wake:
  - Arm level 1 with count 1 and level 3 with count 2; threads 0 -> L1, 4 and 9 -> L3 complete both levels.
  - Arm level 4 with count 2; thread 1 -> L4 leaves it gathering.
  - Release -> mask = 0x0211, level 4 still GATHER (out_wait = 10000).
- Protocol errors, each on a fresh reset so out_error can be checked individually:
  - Duplicate thread 3 to level 2 -> counter unchanged, out_error = 1.
  - Arrival to an IDLE level -> out_error = 1.
  - Re-config of a GATHER level -> out_error = 1.
  - Release during WAKE -> out_error = 1.
- Backpressure and priority:
  - Hold in_wake_ready low for 5 cycles -> mask stable and out_arrive_ready = 0 throughout.
  - Config and arrival on the same cycle -> out_arrive_ready = 0, arrival retried the next cycle.
- Boundaries:
  - Config count 0 -> out_wait bit never rises; release wakes mask 0x0000 with out_wake_valid = 1.
  - Arrival completing a level on the release edge -> that thread is included in the mask.
  - Reset asserted mid-WAKE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/barrier_arrival_tracker.sv
// Per-level arrival collector feeding the multilevel barrier: arms levels, gathers thread arrivals, returns wake masks.
// One-cycle registered update; arrivals stall (ready low) while a wake mask waits for in_wake_ready.
module barrier_arrival_tracker #(
  parameter int NUM_LEVELS  = 5,
  parameter int NUM_THREADS = 16,
  parameter int LEVEL_W     = $clog2(NUM_LEVELS),
  parameter int THREAD_W    = $clog2(NUM_THREADS),
  parameter int CNT_W       = $clog2(NUM_THREADS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_config_valid,
  input  logic [LEVEL_W-1:0]     in_config_level,
  input  logic [CNT_W-1:0]       in_config_count,
  input  logic                   in_arrive_valid,
  input  logic [LEVEL_W-1:0]     in_arrive_level,
  input  logic [THREAD_W-1:0]    in_arrive_thread,
  output logic                   out_arrive_ready,
  output logic [NUM_LEVELS-1:0]  out_wait,
  input  logic                   in_release,
  output logic                   out_wake_valid,
  output logic [NUM_THREADS-1:0] out_wake_mask,
  input  logic                   in_wake_ready,
  output logic                   out_error
);

  typedef enum logic [1:0] {LVL_IDLE, LVL_GATHER, LVL_DONE} lvl_state_t;
  typedef enum logic {G_RUN, G_WAKE} glb_state_t;

  lvl_state_t             lvl_state [NUM_LEVELS];
  lvl_state_t             lvl_nxt   [NUM_LEVELS];
  logic [CNT_W-1:0]       cnt       [NUM_LEVELS];
  logic [CNT_W-1:0]       cnt_nxt   [NUM_LEVELS];
  logic [CNT_W-1:0]       expd      [NUM_LEVELS];
  logic [CNT_W-1:0]       expd_nxt  [NUM_LEVELS];
  logic [NUM_THREADS-1:0] tmask     [NUM_LEVELS];
  logic [NUM_THREADS-1:0] tmask_nxt [NUM_LEVELS];

  glb_state_t             glb, glb_nxt;
  logic [NUM_THREADS-1:0] wake_mask, wake_mask_nxt;
  logic                   error_flag, error_nxt;

  logic                   arrive_acc;
  logic                   wake_hs;
  logic                   done_any;
  logic [NUM_THREADS-1:0] done_mask;
  logic [CNT_W-1:0]       cnt_inc;

  assign out_arrive_ready = (glb == G_RUN) & ~in_config_valid & reset;
  assign arrive_acc       = in_arrive_valid & out_arrive_ready;
  assign wake_hs          = (glb == G_WAKE) & in_wake_ready;
  assign out_wake_valid   = (glb == G_WAKE);
  assign out_wake_mask    = wake_mask;
  assign out_error        = error_flag;

  always_comb begin
    for (int l = 0; l < NUM_LEVELS; l++) begin
      out_wait[l] = (lvl_state[l] == LVL_GATHER);
    end
  end

  always_comb begin
    glb_nxt       = glb;
    wake_mask_nxt = wake_mask;
    error_nxt     = error_flag;
    done_any      = 1'b0;
    done_mask     = '0;
    cnt_inc       = '0;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      lvl_nxt[l]   = lvl_state[l];
      cnt_nxt[l]   = cnt[l];
      expd_nxt[l]  = expd[l];
      tmask_nxt[l] = tmask[l];
    end

    if (in_config_valid && int'(in_config_level) >= NUM_LEVELS) error_nxt = 1'b1;
    if (arrive_acc && int'(in_arrive_level) >= NUM_LEVELS) error_nxt = 1'b1;

    for (int l = 0; l < NUM_LEVELS; l++) begin
      if (in_config_valid && int'(in_config_level) == l) begin
        if (lvl_state[l] == LVL_IDLE) begin
          expd_nxt[l]  = in_config_count;
          cnt_nxt[l]   = '0;
          tmask_nxt[l] = '0;
          lvl_nxt[l]   = (in_config_count == '0) ? LVL_DONE : LVL_GATHER;
        end else begin
          error_nxt = 1'b1;
        end
      end
      // Config and arrival never hit the same level on one edge: ready is low while config is valid.
      if (arrive_acc && int'(in_arrive_level) == l) begin
        if (lvl_state[l] == LVL_GATHER && !tmask[l][in_arrive_thread]) begin
          cnt_inc                        = cnt[l] + 1'b1;
          cnt_nxt[l]                     = cnt_inc;
          tmask_nxt[l][in_arrive_thread] = 1'b1;
          if (cnt_inc == expd[l]) lvl_nxt[l] = LVL_DONE;
        end else begin
          error_nxt = 1'b1;
        end
      end
      // Only levels that were already complete belong to the mask being handed back.
      if (wake_hs && lvl_state[l] == LVL_DONE) begin
        lvl_nxt[l]   = LVL_IDLE;
        cnt_nxt[l]   = '0;
        tmask_nxt[l] = '0;
      end
    end

    // Release sees post-arrival state so a completing arrival on the same edge joins the mask.
    for (int l = 0; l < NUM_LEVELS; l++) begin
      if (lvl_nxt[l] == LVL_DONE) begin
        done_any  = 1'b1;
        done_mask = done_mask | tmask_nxt[l];
      end
    end

    if (wake_hs) begin
      glb_nxt       = G_RUN;
      wake_mask_nxt = '0;
    end
    if (in_release) begin
      if (glb == G_WAKE) begin
        error_nxt = 1'b1;
      end else if (done_any) begin
        glb_nxt       = G_WAKE;
        wake_mask_nxt = done_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      glb        <= G_RUN;
      wake_mask  <= '0;
      error_flag <= 1'b0;
      for (int l = 0; l < NUM_LEVELS; l++) begin
        lvl_state[l] <= LVL_IDLE;
        cnt[l]       <= '0;
        expd[l]      <= '0;
        tmask[l]     <= '0;
      end
    end else begin
      glb        <= glb_nxt;
      wake_mask  <= wake_mask_nxt;
      error_flag <= error_nxt;
      for (int l = 0; l < NUM_LEVELS; l++) begin
        lvl_state[l] <= lvl_nxt[l];
        cnt[l]       <= cnt_nxt[l];
        expd[l]      <= expd_nxt[l];
        tmask[l]     <= tmask_nxt[l];
      end
    end
  end

endmodule

// File: tb/tb_barrier_arrival_tracker.sv
// Bench for barrier_arrival_tracker: directed vector table, corner-case sequences, randomized run against a set-based model.
module tb_barrier_arrival_tracker;
  localparam int NL = 5;
  localparam int NT = 16;
  localparam int LW = 3;
  localparam int TW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_config_valid;
  logic [LW-1:0] in_config_level;
  logic [CW-1:0] in_config_count;
  logic          in_arrive_valid;
  logic [LW-1:0] in_arrive_level;
  logic [TW-1:0] in_arrive_thread;
  logic          out_arrive_ready;
  logic [NL-1:0] out_wait;
  logic          in_release;
  logic          out_wake_valid;
  logic [NT-1:0] out_wake_mask;
  logic          in_wake_ready;
  logic          out_error;

  barrier_arrival_tracker dut (
    .clk(clk), .reset(reset),
    .in_config_valid(in_config_valid), .in_config_level(in_config_level), .in_config_count(in_config_count),
    .in_arrive_valid(in_arrive_valid), .in_arrive_level(in_arrive_level), .in_arrive_thread(in_arrive_thread),
    .out_arrive_ready(out_arrive_ready), .out_wait(out_wait), .in_release(in_release),
    .out_wake_valid(out_wake_valid), .out_wake_mask(out_wake_mask), .in_wake_ready(in_wake_ready),
    .out_error(out_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit cv; int cl; int cc; bit av; int al; int at; bit rel; bit wr;
    bit rdy; int wt; bit wv; int mask; bit err;
  } vec_t;
  vec_t tbl[19];

  // Reference model: armed flag, expected count and set of arrived threads per level.
  bit m_armed[NL];
  int m_exp[NL];
  bit m_mem[NL][NT];
  bit m_wpend;
  int m_wmask;
  bit m_err;

  function automatic vec_t v(bit cv, int cl, int cc, bit av, int al, int at, bit rel, bit wr,
                             bit rdy, int wt, bit wv, int mask, bit err);
    vec_t r;
    r.cv = cv; r.cl = cl; r.cc = cc; r.av = av; r.al = al; r.at = at; r.rel = rel; r.wr = wr;
    r.rdy = rdy; r.wt = wt; r.wv = wv; r.mask = mask; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit cv, int cl, int cc, bit av, int al, int at, bit rel, bit wr);
    in_config_valid  = cv;
    in_config_level  = LW'(cl);
    in_config_count  = CW'(cc);
    in_arrive_valid  = av;
    in_arrive_level  = LW'(al);
    in_arrive_thread = TW'(at);
    in_release       = rel;
    in_wake_ready    = wr;
  endtask

  task automatic step(bit cv, int cl, int cc, bit av, int al, int at, bit rel, bit wr);
    drive(cv, cl, cc, av, al, at, rel, wr);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_outs(input string tag, int wt, bit wv, int mask, bit err);
    chk({tag, ".wait"}, 32'(out_wait), 32'(wt));
    chk({tag, ".wake_valid"}, 32'(out_wake_valid), 32'(wv));
    chk({tag, ".wake_mask"}, 32'(out_wake_mask), 32'(mask));
    chk({tag, ".error"}, 32'(out_error), 32'(err));
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_armed[l] = 0;
      m_exp[l] = 0;
      for (int t = 0; t < NT; t++) m_mem[l][t] = 0;
    end
    m_wpend = 0;
    m_wmask = 0;
    m_err = 0;
  endtask

  function automatic int m_count(int l);
    int c = 0;
    for (int t = 0; t < NT; t++) c += int'(m_mem[l][t]);
    return c;
  endfunction

  function automatic bit m_done(int l);
    return m_armed[l] && m_count(l) == m_exp[l];
  endfunction

  function automatic int m_waitbits();
    int w = 0;
    for (int l = 0; l < NL; l++) if (m_armed[l] && m_count(l) < m_exp[l]) w |= (1 << l);
    return w;
  endfunction

  task automatic model_step(bit cv, int cl, int cc, bit av, int al, int at, bit rel, bit wr);
    bit was_wake;
    bit acc;
    bit done_before[NL];
    bit any;
    int msk;
    was_wake = m_wpend;
    acc = av && !was_wake && !cv;
    for (int l = 0; l < NL; l++) done_before[l] = m_done(l);
    if (cv) begin
      if (cl < NL && !m_armed[cl]) begin
        m_armed[cl] = 1;
        m_exp[cl] = cc;
        for (int t = 0; t < NT; t++) m_mem[cl][t] = 0;
      end else m_err = 1;
    end
    if (acc) begin
      if (al < NL && m_armed[al] && m_count(al) < m_exp[al] && !m_mem[al][at]) m_mem[al][at] = 1;
      else m_err = 1;
    end
    if (was_wake && wr) begin
      for (int l = 0; l < NL; l++) begin
        if (done_before[l]) begin
          m_armed[l] = 0;
          for (int t = 0; t < NT; t++) m_mem[l][t] = 0;
        end
      end
      m_wpend = 0;
      m_wmask = 0;
    end
    if (rel) begin
      if (was_wake) m_err = 1;
      else begin
        any = 0;
        msk = 0;
        for (int l = 0; l < NL; l++) begin
          if (m_done(l)) begin
            any = 1;
            for (int t = 0; t < NT; t++) if (m_mem[l][t]) msk |= (1 << t);
          end
        end
        if (any) begin
          m_wpend = 1;
          m_wmask = msk;
        end
      end
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc();
    cyc();
    chk("rst_low.ready", 32'(out_arrive_ready), 32'd0);
    chk_outs("rst_low", 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rst_rel.ready", 32'(out_arrive_ready), 32'd1);
    chk_outs("rst_rel", 0, 0, 0, 0);
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    //          cv cl cc  av al at  rel wr  rdy wait   wv mask    err
    tbl[0]  = v(1, 0, 3,  0, 0, 0,  0, 0,   0, 'h01,  0, 'h000,  0);
    tbl[1]  = v(0, 0, 0,  1, 0, 2,  0, 0,   1, 'h01,  0, 'h000,  0);
    tbl[2]  = v(0, 0, 0,  1, 0, 5,  0, 0,   1, 'h01,  0, 'h000,  0);
    tbl[3]  = v(0, 0, 0,  1, 0, 7,  0, 0,   1, 'h00,  0, 'h000,  0);
    tbl[4]  = v(0, 0, 0,  0, 0, 0,  1, 0,   1, 'h00,  1, 'h0A4,  0);
    tbl[5]  = v(0, 0, 0,  0, 0, 0,  0, 1,   0, 'h00,  0, 'h000,  0);
    tbl[6]  = v(1, 1, 1,  0, 0, 0,  0, 0,   0, 'h02,  0, 'h000,  0);
    tbl[7]  = v(1, 3, 2,  0, 0, 0,  0, 0,   0, 'h0A,  0, 'h000,  0);
    tbl[8]  = v(0, 0, 0,  1, 1, 0,  0, 0,   1, 'h08,  0, 'h000,  0);
    tbl[9]  = v(0, 0, 0,  1, 3, 4,  0, 0,   1, 'h08,  0, 'h000,  0);
    tbl[10] = v(0, 0, 0,  1, 3, 9,  0, 0,   1, 'h00,  0, 'h000,  0);
    tbl[11] = v(1, 4, 2,  0, 0, 0,  0, 0,   0, 'h10,  0, 'h000,  0);
    tbl[12] = v(0, 0, 0,  1, 4, 1,  0, 0,   1, 'h10,  0, 'h000,  0);
    tbl[13] = v(0, 0, 0,  0, 0, 0,  1, 0,   1, 'h10,  1, 'h211,  0);
    tbl[14] = v(0, 0, 0,  1, 4, 6,  0, 0,   0, 'h10,  1, 'h211,  0);
    tbl[15] = v(0, 0, 0,  0, 0, 0,  0, 1,   0, 'h10,  0, 'h000,  0);
    tbl[16] = v(0, 0, 0,  1, 4, 6,  1, 0,   1, 'h00,  1, 'h042,  0);
    tbl[17] = v(0, 0, 0,  0, 0, 0,  0, 1,   0, 'h00,  0, 'h000,  0);
    tbl[18] = v(0, 0, 0,  0, 0, 0,  0, 0,   1, 'h00,  0, 'h000,  0);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].cv, tbl[i].cl, tbl[i].cc, tbl[i].av, tbl[i].al, tbl[i].at, tbl[i].rel, tbl[i].wr);
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(out_arrive_ready), 32'(tbl[i].rdy));
      cyc();
      chk_outs($sformatf("vec%0d", i), tbl[i].wt, tbl[i].wv, tbl[i].mask, tbl[i].err);
    end

    // Duplicate arrival: error set, count unchanged (still needs two distinct threads).
    do_reset();
    step(1, 2, 3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 3, 0, 0);
    chk_outs("dup_first", 'h04, 0, 0, 0);
    step(0, 0, 0, 1, 2, 3, 0, 0);
    chk_outs("dup_again", 'h04, 0, 0, 1);
    step(0, 0, 0, 1, 2, 4, 0, 0);
    chk_outs("dup_cnt2", 'h04, 0, 0, 1);
    step(0, 0, 0, 1, 2, 5, 0, 0);
    chk_outs("dup_cnt3", 'h00, 0, 0, 1);

    do_reset();
    step(0, 0, 0, 1, 0, 1, 0, 0);
    chk_outs("arr_idle", 0, 0, 0, 1);

    do_reset();
    step(1, 1, 2, 0, 0, 0, 0, 0);
    chk_outs("recfg_first", 'h02, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0);
    chk_outs("recfg_gather", 'h02, 0, 0, 1);

    do_reset();
    step(1, 6, 1, 0, 0, 0, 0, 0);
    chk_outs("cfg_badidx", 0, 0, 0, 1);

    do_reset();
    step(0, 0, 0, 1, 7, 2, 0, 0);
    chk_outs("arr_badidx", 0, 0, 0, 1);

    // Release in WAKE is a protocol error but leaves the pending mask alone.
    do_reset();
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk_outs("rel_wake1", 0, 1, 'h0001, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk_outs("rel_wake2", 0, 1, 'h0001, 1);

    // Wake backpressure: mask held, arrivals stalled.
    do_reset();
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 1, 2, 0, 0);
      #1;
      chk($sformatf("bp%0d.ready", i), 32'(out_arrive_ready), 32'd0);
      cyc();
      chk_outs($sformatf("bp%0d", i), 0, 1, 'h0008, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("bp_hs.ready", 32'(out_arrive_ready), 32'd1);
    chk_outs("bp_hs", 0, 0, 0, 0);

    // Config and arrival on one edge: arrival held off, retried next cycle.
    drive(1, 1, 1, 1, 1, 2, 0, 0);
    #1;
    chk("prio.ready", 32'(out_arrive_ready), 32'd0);
    cyc();
    chk_outs("prio_cfg", 'h02, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 2, 0, 0);
    #1;
    chk("retry.ready", 32'(out_arrive_ready), 32'd1);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_outs("retry", 'h00, 0, 0, 0);

    // Zero-count level: never gathers, releases an empty mask, re-armable right after handshake.
    do_reset();
    step(1, 2, 0, 0, 0, 0, 0, 0);
    chk_outs("cnt0_a", 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_outs("cnt0_b", 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk_outs("cnt0_rel", 0, 1, 'h0000, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk_outs("cnt0_hs", 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0, 0);
    chk_outs("cnt0_rearm", 'h04, 0, 0, 0);

    // Reset in the middle of WAKE clears everything, including the sticky error.
    do_reset();
    step(0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk_outs("midwake_pre", 0, 1, 'h0020, 1);
    reset = 1'b0;
    cyc();
    chk("midwake_rst.ready", 32'(out_arrive_ready), 32'd0);
    chk_outs("midwake_rst", 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("midwake_after.ready", 32'(out_arrive_ready), 32'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bit cv, av, rel, wr;
      int cl, cc, al, at;
      if (c > 0 && c % 250 == 0) do_reset();
      cv  = ($urandom_range(0, 99) < 15);
      cl  = ($urandom_range(0, 99) < 3) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      cc  = ($urandom_range(0, 99) < 5) ? int'($urandom_range(4, 16)) : int'($urandom_range(0, 3));
      av  = ($urandom_range(0, 99) < 55);
      al  = ($urandom_range(0, 99) < 3) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      at  = ($urandom_range(0, 99) < 20) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
      rel = !cv && ($urandom_range(0, 99) < 12);
      wr  = ($urandom_range(0, 99) < 40);
      drive(cv, cl, cc, av, al, at, rel, wr);
      #1;
      chk("rnd.ready", 32'(out_arrive_ready), 32'(!m_wpend && !cv));
      model_step(cv, cl, cc, av, al, at, rel, wr);
      cyc();
      chk_outs("rnd", m_waitbits(), m_wpend, m_wmask, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
